fetch_ctrl: RTL and testbench

- Instruction-fetch sequencer that owns the architectural PC register and drives the instruction-memory request interface.
- Presents fetched instructions to decode through a registered IF stage and absorbs decode back-pressure (stall) with a one-entry hold buffer.
- Accepts branch/jump redirects from the PC-control / branch-resolution logic and generates a one-cycle flush.
- Stops fetching on HLT and reports halted.

---
 rtl/fetch_ctrl.sv | 114 +++++++++++
 tb/tb_fetch_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives instruction-memory requests,
// and presents fetched words to decode through a registered IF stage.
module fetch_ctrl #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [3:0]  HLT_OPCODE = 4'hF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        imem_ready,
  input  logic [15:0] imem_data,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  output logic        if_valid,
  output logic [15:0] if_instr,
  output logic [15:0] if_pc,
  output logic [15:0] if_pc_plus2,
  output logic        flush,
  output logic        halted
);

  typedef enum logic [2:0] {IDLE, REQ, HOLD, DRAIN, HALT} state_t;

  state_t      state, state_next;
  logic [15:0] pc;
  logic [15:0] drain_addr;
  logic [15:0] hold_buf;
  logic [15:0] load_data;
  logic        load_if;
  logic        buf_load;
  logic        drain_start;
  logic        take_redirect;

  assign take_redirect = redirect && (state != IDLE);
  assign imem_req      = (state == REQ) || (state == DRAIN);
  // DRAIN keeps presenting the abandoned address until memory answers it.
  assign imem_addr     = (state == DRAIN) ? drain_addr : pc;
  assign halted        = (state == HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next  = state;
    load_if     = 1'b0;
    load_data   = imem_data;
    buf_load    = 1'b0;
    drain_start = 1'b0;
    case (state)
      IDLE: state_next = REQ;
      REQ: begin
        if (redirect) begin
          state_next  = imem_ready ? REQ : DRAIN;
          drain_start = !imem_ready;
        end else if (imem_ready) begin
          if (!stall) begin
            load_if    = 1'b1;
            state_next = (imem_data[15:12] == HLT_OPCODE) ? HALT : REQ;
          end else begin
            buf_load   = 1'b1;
            state_next = HOLD;
          end
        end
      end
      HOLD: begin
        if (redirect) begin
          state_next = REQ;
        end else if (!stall) begin
          load_if    = 1'b1;
          load_data  = hold_buf;
          state_next = (hold_buf[15:12] == HLT_OPCODE) ? HALT : REQ;
        end
      end
      DRAIN: if (imem_ready) state_next = REQ;
      HALT:  if (redirect) state_next = REQ;
      default: state_next = IDLE;
    endcase
  end

  // Redirect wins over everything, including a stalled IF stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      drain_addr  <= 16'h0000;
      hold_buf    <= 16'h0000;
      if_valid    <= 1'b0;
      if_instr    <= 16'h0000;
      if_pc       <= 16'h0000;
      if_pc_plus2 <= 16'h0000;
      flush       <= 1'b0;
    end else begin
      flush <= take_redirect;
      if (buf_load)    hold_buf   <= imem_data;
      if (drain_start) drain_addr <= pc;
      if (take_redirect) begin
        pc       <= redirect_pc & 16'hFFFE;
        if_valid <= 1'b0;
      end else if (load_if) begin
        if_valid    <= 1'b1;
        if_instr    <= load_data;
        if_pc       <= pc;
        if_pc_plus2 <= pc + 16'd2;
        pc          <= pc + 16'd2;
      end else if (!stall) begin
        if_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a scoreboard queue of expected decoded instructions
// is filled by the stimulus and drained by a monitor whenever decode accepts one.
module tb_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        imem_ready;
  logic [15:0] imem_data;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic [15:0] if_pc_plus2;
  logic        flush;
  logic        halted;

  int compared;
  int mismatched;
  logic [47:0] sb[$];

  fetch_ctrl #(.RESET_PC(16'h0000), .HLT_OPCODE(4'hF)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_ready(imem_ready), .imem_data(imem_data),
    .imem_req(imem_req), .imem_addr(imem_addr), .if_valid(if_valid),
    .if_instr(if_instr), .if_pc(if_pc), .if_pc_plus2(if_pc_plus2),
    .flush(flush), .halted(halted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    case (a)
      16'h0000: return 16'h1234;
      16'h0002: return 16'h5678;
      16'h0010: return 16'hF000;
      default:  return {4'h2, a[11:0]};
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Inputs change on the falling edge; memory answers the request visible right now.
  task automatic applyStimulus(input logic st, input logic rd, input logic [15:0] rpc, input logic men);
    @(negedge clk);
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    imem_ready  = imem_req && men;
    imem_data   = mem_word(imem_addr);
    #3;
  endtask

  task automatic pushExp(input logic [15:0] instr, input logic [15:0] pc, input logic [15:0] pc2);
    sb.push_back({instr, pc, pc2});
  endtask

  // Decode takes the IF contents on any edge where they are valid and not stalled.
  initial begin
    logic [47:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && if_valid && !stall) begin
        if (sb.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL mon_unexpected: got instr %h at pc %h, expected none", if_instr, if_pc);
        end else begin
          e = sb.pop_front();
          checkOutput("mon_instr", if_instr, e[47:32]);
          checkOutput("mon_pc", if_pc, e[31:16]);
          checkOutput("mon_pc_plus2", if_pc_plus2, e[15:0]);
        end
      end
    end
  end

  initial begin
    rst_n       = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0000;
    imem_ready  = 1'b0;
    imem_data   = 16'h0000;
    #2;
    checkOutput("rst_imem_req", {15'd0, imem_req}, 16'd0);
    checkOutput("rst_if_valid", {15'd0, if_valid}, 16'd0);
    checkOutput("rst_flush", {15'd0, flush}, 16'd0);
    checkOutput("rst_halted", {15'd0, halted}, 16'd0);
    checkOutput("rst_if_instr", if_instr, 16'h0000);
    checkOutput("rst_if_pc", if_pc, 16'h0000);
    checkOutput("rst_if_pc_plus2", if_pc_plus2, 16'h0000);

    @(negedge clk);
    rst_n = 1'b1;
    #3;
    checkOutput("idle_no_req", {15'd0, imem_req}, 16'd0);

    // Back-to-back single-cycle memory
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
    checkOutput("first_req", {15'd0, imem_req}, 16'd1);
    checkOutput("first_addr", imem_addr, 16'h0000);
    pushExp(16'h1234, 16'h0000, 16'h0002);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
    checkOutput("second_addr", imem_addr, 16'h0002);
    pushExp(16'h5678, 16'h0002, 16'h0004);

    // Stall while the 0004 response arrives
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1);
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1);
    checkOutput("hold_no_req", {15'd0, imem_req}, 16'd0);
    checkOutput("hold_if_pc", if_pc, 16'h0002);
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1);
    checkOutput("hold_if_instr", if_instr, 16'h5678);
    checkOutput("hold_if_valid", {15'd0, if_valid}, 16'd1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
    pushExp(16'h2004, 16'h0004, 16'h0006);

    // Redirect to 0041 while 0006 is outstanding
    applyStimulus(1'b0, 1'b1, 16'h0041, 1'b0);
    checkOutput("pending_addr", imem_addr, 16'h0006);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    checkOutput("redir_flush", {15'd0, flush}, 16'd1);
    checkOutput("drain_req", {15'd0, imem_req}, 16'd1);
    checkOutput("drain_addr", imem_addr, 16'h0006);
    checkOutput("redir_if_valid", {15'd0, if_valid}, 16'd0);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
    checkOutput("flush_one_cycle", {15'd0, flush}, 16'd0);
    checkOutput("drain_addr_held", imem_addr, 16'h0006);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
    checkOutput("post_drain_addr", imem_addr, 16'h0040);
    checkOutput("drained_not_valid", {15'd0, if_valid}, 16'd0);
    pushExp(16'h2040, 16'h0040, 16'h0042);

    // Double redirect: second one lands while draining 0042
    applyStimulus(1'b0, 1'b1, 16'h0030, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h0011, 1'b1);
    checkOutput("drain2_addr", imem_addr, 16'h0042);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
    checkOutput("redir2_flush", {15'd0, flush}, 16'd1);
    checkOutput("hlt_fetch_addr", imem_addr, 16'h0010);
    pushExp(16'hF000, 16'h0010, 16'h0012);

    // Halt, HLT word held through a stall, then cleared once accepted
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1);
    checkOutput("halted_set", {15'd0, halted}, 16'd1);
    checkOutput("halt_no_req", {15'd0, imem_req}, 16'd0);
    checkOutput("halt_if_instr", if_instr, 16'hF000);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
    checkOutput("halt_valid_held", {15'd0, if_valid}, 16'd1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
    checkOutput("halt_valid_cleared", {15'd0, if_valid}, 16'd0);
    checkOutput("halt_still_no_req", {15'd0, imem_req}, 16'd0);
    applyStimulus(1'b0, 1'b1, 16'h0100, 1'b1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
    checkOutput("unhalted", {15'd0, halted}, 16'd0);
    checkOutput("unhalt_addr", imem_addr, 16'h0100);
    pushExp(16'h2100, 16'h0100, 16'h0102);

    // PC wrap: redirect with a response in flight drops it, then FFFC, FFFE, 0000
    applyStimulus(1'b0, 1'b1, 16'hFFFC, 1'b1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
    checkOutput("wrap_addr_fffc", imem_addr, 16'hFFFC);
    pushExp(16'h2FFC, 16'hFFFC, 16'hFFFE);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
    checkOutput("wrap_addr_fffe", imem_addr, 16'hFFFE);
    pushExp(16'h2FFE, 16'hFFFE, 16'h0000);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
    checkOutput("wrap_addr_0000", imem_addr, 16'h0000);
    pushExp(16'h1234, 16'h0000, 16'h0002);

    // Reach a pending request at 0020 with a valid IF entry, then reset mid-cycle
    applyStimulus(1'b0, 1'b1, 16'h001E, 1'b0);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
    checkOutput("pre_rst_addr", imem_addr, 16'h001E);
    pushExp(16'h201E, 16'h001E, 16'h0020);
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
    checkOutput("pending_0020", imem_addr, 16'h0020);
    checkOutput("pending_req", {15'd0, imem_req}, 16'd1);
    checkOutput("pending_if_valid", {15'd0, if_valid}, 16'd1);
    checkOutput("sb_only_last", 16'(sb.size()), 16'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_req", {15'd0, imem_req}, 16'd0);
    checkOutput("async_rst_valid", {15'd0, if_valid}, 16'd0);
    checkOutput("async_rst_halted", {15'd0, halted}, 16'd0);
    sb.delete();

    @(negedge clk);
    rst_n = 1'b1;
    #3;
    checkOutput("idle2_no_req", {15'd0, imem_req}, 16'd0);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    checkOutput("restart_req", {15'd0, imem_req}, 16'd1);
    checkOutput("restart_addr", imem_addr, 16'h0000);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    checkOutput("sb_empty", 16'(sb.size()), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
